// File: rtl/time_parameters_with_reprogrammability.sv
// time_parameters_with_reprogrammability: four reprogrammable timer parameters for the car security FSM.
// Define TIME_PARAM_ZERO_CLAMP_EN to store 1 whenever 0 is written.
module time_parameters_with_reprogrammability #(
  parameter int WIDTH = 4,
  parameter int DEFAULT_ARM_DELAY = 6,
  parameter int DEFAULT_DRIVER_DELAY = 8,
  parameter int DEFAULT_PASSENGER_DELAY = 15,
  parameter int DEFAULT_ALARM_ON = 10
) (
  input  logic             clock,
  input  logic             systemReset,
  input  logic             reprogram,
  input  logic [1:0]       timeParameterSelector,
  input  logic [WIDTH-1:0] timeValue,
  input  logic [1:0]       interval,
  output logic [WIDTH-1:0] value,
  output logic             reprogramDone
);
  logic [WIDTH-1:0] slot [4];
  logic [2:0] sync;
  logic write_strobe;
  logic [WIDTH-1:0] wdata;
  // Sync flops reset high so a button held through reset release is not seen as an edge
  assign write_strobe = sync[1] & ~sync[2];
`ifdef TIME_PARAM_ZERO_CLAMP_EN
  assign wdata = (timeValue == '0) ? WIDTH'(1) : timeValue;
`else
  assign wdata = timeValue;
`endif
  assign value = slot[interval];
  always_ff @(posedge clock or negedge systemReset) begin
    if (!systemReset) begin
      sync <= 3'b111;
      reprogramDone <= 1'b0;
      slot[0] <= WIDTH'(DEFAULT_ARM_DELAY);
      slot[1] <= WIDTH'(DEFAULT_DRIVER_DELAY);
      slot[2] <= WIDTH'(DEFAULT_PASSENGER_DELAY);
      slot[3] <= WIDTH'(DEFAULT_ALARM_ON);
    end else begin
      sync <= {sync[1:0], reprogram};
      reprogramDone <= write_strobe;
      if (write_strobe) slot[timeParameterSelector] <= wdata;
    end
  end
endmodule

// File: tb/tb_time_parameters_with_reprogrammability.sv
// tb_time_parameters_with_reprogrammability: directed and random checks of parameter storage and reprogramming.
module tb_time_parameters_with_reprogrammability;
  logic clock = 0;
  logic systemReset = 0;
  logic reprogram = 0;
  logic [1:0] timeParameterSelector = 0;
  logic [3:0] timeValue = 0;
  logic [1:0] interval = 0;
  logic [3:0] value;
  logic reprogramDone;
  int n_cmp = 0;
  int n_bad = 0;
  int model [4];

  time_parameters_with_reprogrammability dut (
    .clock(clock), .systemReset(systemReset), .reprogram(reprogram),
    .timeParameterSelector(timeParameterSelector), .timeValue(timeValue),
    .interval(interval), .value(value), .reprogramDone(reprogramDone)
  );

  always #5 clock = ~clock;

  function automatic int stored(input int v);
`ifdef TIME_PARAM_ZERO_CLAMP_EN
    return (v == 0) ? 1 : v;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_defaults();
    model[0] = 6; model[1] = 8; model[2] = 15; model[3] = 10;
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 4; i++) begin
      interval = 2'(i);
      #1;
      chk(tag, int'(value), model[i]);
    end
  endtask

  // Raise reprogram for `hold` edges; timeValue switches to v2 after edge 5 to prove only the commit edge samples it
  task automatic do_write(input int s, input int v, input int v2, input int hold, input int rd);
    int pulses, first, old_v, new_v;
    pulses = 0; first = 0;
    old_v = model[s]; new_v = stored(v);
    @(negedge clock);
    timeParameterSelector = 2'(s); timeValue = 4'(v); interval = 2'(rd); reprogram = 1;
    for (int e = 1; e <= hold; e++) begin
      @(posedge clock); #1;
      if (reprogramDone) begin pulses++; if (first == 0) first = e; end
      if (rd == s && e <= 3) chk("read_during_write", int'(value), (e < 3) ? old_v : new_v);
      if (e == 5) timeValue = 4'(v2);
    end
    @(negedge clock); reprogram = 0;
    for (int e = 0; e < 3; e++) begin
      @(posedge clock); #1;
      if (reprogramDone) pulses++;
    end
    chk("done_pulses", pulses, 1);
    chk("commit_edge", first, 3);
    model[s] = new_v;
  endtask

  initial begin
    set_defaults();
    repeat (2) @(negedge clock);
    chk("reset_done", int'(reprogramDone), 0);
    sweep("reset_value");
    systemReset = 1;
    @(negedge clock);
    sweep("after_release");

    do_write(0, 7, 7, 4, 1);
    do_write(1, 4, 4, 4, 2);
    do_write(2, 14, 14, 4, 3);
    do_write(3, 9, 9, 4, 0);
    sweep("prog_sweep");

    do_write(1, 3, 5, 20, 0);
    sweep("long_hold");

    do_write(2, 12, 12, 4, 2);
    sweep("same_slot_read");

    do_write(0, 0, 0, 4, 0);
    interval = 0; #1;
    chk("zero_write", int'(value), stored(0));

    for (int k = 0; k < 12; k++) begin
      int s, v, h, r;
      s = int'($urandom_range(3));
      v = int'($urandom_range(15));
      h = int'($urandom_range(8, 4));
      r = int'($urandom_range(3));
      do_write(s, v, v, h, r);
      sweep("random_sweep");
    end

    // Reset in the middle of a write, with reprogram held through release
    @(negedge clock);
    timeParameterSelector = 3; timeValue = 2; reprogram = 1;
    @(posedge clock); #2;
    systemReset = 0;
    #1;
    set_defaults();
    sweep("mid_reset_async");
    @(negedge clock); @(negedge clock);
    systemReset = 1;
    begin
      int pulses = 0;
      for (int e = 0; e < 6; e++) begin
        @(posedge clock); #1;
        if (reprogramDone) pulses++;
      end
      chk("held_through_release", pulses, 0);
    end
    sweep("after_mid_reset");
    @(negedge clock); reprogram = 0;
    repeat (3) @(negedge clock);

    do_write(3, 2, 2, 4, 3);
    sweep("post_reset_write");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
